divisor_preco_peso_seq: RTL and testbench

//   Inverse of the scale's weight x unit-price multiplier. Sequential block: given a target price
//   and a price per kg, computes peso = (preco * ESCALA) / preco_kg, i.e. the weight that yields

---
 rtl/balanca_pkg.sv | 27 ++
 rtl/divisor_restaurador_seq.sv | 49 ++++
 rtl/divisor_preco_peso_seq.sv | 105 ++++++++++
 tb/tb_divisor_preco_peso_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/balanca_pkg.sv
// Shared constants, state type and price scaling for the price->weight divider.
// Build option: DIV_ROUND_EN selects round-to-nearest (one extra dividend bit and step).
package balanca_pkg;

    localparam int W_PRECO    = 11;
    localparam int W_PRECO_KG = 9;
    localparam int W_PESO     = 11;
    localparam int ESCALA     = 1000;
`ifdef DIV_ROUND_EN
    localparam int W_DIV      = W_PRECO + 11;
`else
    localparam int W_DIV      = W_PRECO + 10;
`endif
    localparam int W_CNT      = $clog2(W_DIV);

    localparam logic [W_PESO-1:0] PESO_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} estado_t;

    // x*1000 as x*1024 - x*16 - x*8, cheaper than a generic multiplier
    function automatic logic [W_DIV-1:0] escala_mul(input logic [W_PRECO-1:0] x);
        logic [W_DIV-1:0] xe;
        xe = W_DIV'(x);
        return (xe << 10) - (xe << 4) - (xe << 3);
    endfunction

endpackage

// File: rtl/divisor_restaurador_seq.sv
// Generic restoring divider core: one quotient bit per step, MSB of dividend first.
module divisor_restaurador_seq #(
    parameter int W_DIV = 21,
    parameter int W_DSR = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [W_DIV-1:0] dividend,
    input  logic [W_DSR-1:0] divisor,
    output logic [W_DIV-1:0] quociente,
    output logic [W_DIV-1:0] quociente_prox,
    output logic [W_DSR-1:0] resto
);

    logic [W_DIV-1:0] dvd;
    logic [W_DSR-1:0] dsr;
    logic [W_DSR:0]   rem_sh;
    logic [W_DSR:0]   rem_nx;
    logic             q_bit;

    always_comb begin
        rem_sh = {resto, dvd[W_DIV-1]};
        q_bit  = (rem_sh >= {1'b0, dsr});
        rem_nx = q_bit ? (rem_sh - {1'b0, dsr}) : rem_sh;
        quociente_prox = {quociente[W_DIV-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dsr       <= '0;
            resto     <= '0;
            quociente <= '0;
        end else if (load) begin
            dvd       <= dividend;
            dsr       <= divisor;
            resto     <= '0;
            quociente <= '0;
        end else if (step) begin
            dvd       <= dvd << 1;
            // after a restoring step the remainder is always below the divisor
            resto     <= rem_nx[W_DSR-1:0];
            quociente <= quociente_prox;
        end
    end

endmodule

// File: rtl/divisor_preco_peso_seq.sv
// Sell-by-value helper: peso = preco*ESCALA/preco_kg, start/done handshake, saturated result.
// Build option: DIV_ROUND_EN adds floor(preco_kg/2) to the dividend for round-to-nearest.
module divisor_preco_peso_seq
    import balanca_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_PRECO-1:0]    preco_11b,
    input  logic [W_PRECO_KG-1:0] preco_kg_9b,
    output logic                  busy,
    output logic                  done,
    output logic [W_PESO-1:0]     peso_11b,
    output logic                  saturado,
    output logic                  erro_div_zero
);

    estado_t               state, state_nx;
    logic [W_CNT-1:0]      cnt;
    logic [W_PRECO-1:0]    preco_r;
    logic [W_PRECO_KG-1:0] kg_r;
    logic                  div_zero;
    logic [W_DIV-1:0]      dividend;
    logic [W_DIV-1:0]      quociente;
    logic [W_DIV-1:0]      q_final;
    logic [W_PRECO_KG-1:0] resto;

    assign div_zero = (kg_r == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

`ifdef DIV_ROUND_EN
    assign dividend = escala_mul(preco_r) + W_DIV'(kg_r >> 1);
`else
    assign dividend = escala_mul(preco_r);
`endif

    divisor_restaurador_seq #(
        .W_DIV (W_DIV),
        .W_DSR (W_PRECO_KG)
    ) u_core (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (state == LOAD),
        .step           (state == DIV && !div_zero),
        .dividend       (dividend),
        .divisor        (kg_r),
        .quociente      (quociente),
        .quociente_prox (q_final),
        .resto          (resto)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = DIV;
            DIV:     if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            preco_r       <= '0;
            kg_r          <= '0;
            peso_11b      <= '0;
            saturado      <= 1'b0;
            erro_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    preco_r       <= preco_11b;
                    kg_r          <= preco_kg_9b;
                    saturado      <= 1'b0;
                    erro_div_zero <= 1'b0;
                end
                // divide-by-zero still spends one DIV cycle so its latency stays at two clocks
                LOAD: cnt <= div_zero ? '0 : W_CNT'(W_DIV - 1);
                DIV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (div_zero) begin
                        peso_11b      <= PESO_MAX;
                        erro_div_zero <= 1'b1;
                    end else if (q_final > W_DIV'(PESO_MAX)) begin
                        peso_11b <= PESO_MAX;
                        saturado <= 1'b1;
                    end else begin
                        peso_11b <= q_final[W_PESO-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_preco_peso_seq.sv
// Self-checking bench: directed cases, mid-op reset and random requests against an arithmetic model.
module tb_divisor_preco_peso_seq;

`ifdef DIV_ROUND_EN
    localparam int WD = 22;
`else
    localparam int WD = 21;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] preco_11b = '0;
    logic [8:0]  preco_kg_9b = '0;
    logic        busy, done, saturado, erro_div_zero;
    logic [10:0] peso_11b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divisor_preco_peso_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .preco_11b     (preco_11b),
        .preco_kg_9b   (preco_kg_9b),
        .busy          (busy),
        .done          (done),
        .peso_11b      (peso_11b),
        .saturado      (saturado),
        .erro_div_zero (erro_div_zero)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: weight that yields the target price, saturated to 11 bits.
    task automatic model(input int p, input int k, output int peso, output int sat, output int dz);
        longint num, q;
        dz = 0; sat = 0;
        if (k == 0) begin
            peso = 2047; dz = 1;
        end else begin
            num = longint'(p) * 1000;
`ifdef DIV_ROUND_EN
            num = num + k / 2;
`endif
            q = num / k;
            if (q > 2047) begin peso = 2047; sat = 1; end
            else peso = int'(q);
        end
    endtask

    // One request; optionally a second start with new inputs while busy (must be ignored).
    task automatic do_op(input int p, input int k, input bit extra, input string tag);
        int ep, es, ez, lat, exp_lat;
        lat = -1;
        model(p, k, ep, es, ez);
        exp_lat = (k == 0) ? 2 : WD + 1;
        @(negedge clk);
        preco_11b = 11'(p); preco_kg_9b = 9'(k); start = 1'b1;
        @(posedge clk);
        for (int idx = 0; idx <= 40; idx++) begin
            @(negedge clk);
            if (idx == 0) begin
                start = 1'b0;
                preco_11b = 11'($urandom); preco_kg_9b = 9'($urandom);
            end
            if (extra && idx == 5) begin
                start = 1'b1; preco_11b = 11'd7; preco_kg_9b = 9'd1;
            end
            if (extra && idx == 6) start = 1'b0;
            if (done) begin lat = idx; break; end
            chk({tag, "_busy"}, busy, 1);
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_peso"}, peso_11b, ep);
        chk({tag, "_saturado"}, saturado, es);
        chk({tag, "_erro_div_zero"}, erro_div_zero, ez);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_peso_hold"}, peso_11b, ep);
        if (extra) begin
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done || busy) break;
            end
            chk({tag, "_no_second_done"}, done | busy, 0);
        end
    endtask

    initial begin
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_peso", peso_11b, 0);
        chk("reset_flags", {saturado, erro_div_zero}, 0);
        @(negedge clk); rst_n = 1'b1;

        do_op(150, 300, 0, "t1");
        do_op(2, 3, 0, "t2");
        do_op(1000, 333, 0, "t3");
        do_op(500, 0, 0, "t4");
        do_op(1, 1, 0, "min");
        do_op(2047, 511, 0, "max");
        do_op(300, 250, 1, "t5");

        // Reset during DIV aborts the operation
        @(negedge clk);
        preco_11b = 11'd150; preco_kg_9b = 9'd300; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_peso", peso_11b, 0);
        chk("t6_flags", {saturado, erro_div_zero}, 0);
        @(negedge clk); rst_n = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("t6_no_done", seen, 0);
        end
        do_op(150, 300, 0, "t6_after");

        for (int n = 0; n < 20; n++) begin
            int p, k;
            p = int'($urandom_range(0, 2047));
            k = (n % 7 == 3) ? 0 : int'($urandom_range(1, 511));
            do_op(p, k, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
